// File: rtl/core_pkg.sv
// Shared widths, execute payload type and the operand bypass select used by the operand-fetch stage.
// Pure definitions: no state and no latency of its own.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [REG_ADDR_W-1:0] rd_addr;
  } ex_payload_t;

  // x0 reads as zero; a same-cycle writeback beats the register file, whose write lands next edge
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [REG_ADDR_W-1:0] addr,
    input logic                  wb_vld,
    input logic [REG_ADDR_W-1:0] wb_addr,
    input logic [XLEN-1:0]       wb_dat,
    input logic [XLEN-1:0]       rf_dat
  );
    if (addr == '0)                   return '0;
    else if (wb_vld && wb_addr == addr) return wb_dat;
    else                              return rf_dat;
  endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// One pending bit per register: set on issue, cleared on writeback (set wins), flushed to zero.
// Pending updates on the next edge; eff_pending and busy carry no stall of their own.
module operand_scoreboard
  import core_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  set_vld,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_vld,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  output logic [NUM_REGS-1:0]   eff_pending,
  output logic                  busy
);

  localparam logic [NUM_REGS-1:0] WRITABLE = {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_vld) set_mask[set_addr] = 1'b1;
    if (clr_vld) clr_mask[clr_addr] = 1'b1;
  end

  // the writeback in flight this cycle no longer blocks anyone
  assign eff_pending = pending_q & ~clr_mask;
  assign busy        = |pending_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else if (flush_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= ((pending_q & ~clr_mask) | set_mask) & WRITABLE;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: scoreboard hazard stall, writeback bypass, registered hand-off to execute.
// One cycle accept-to-ex_valid_o; id_ready_o drops on hazard, flush or a stalled full output register.
module operand_fetch
  import core_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [XLEN-1:0]       id_pc_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
  output logic [REG_ADDR_W-1:0] rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]       rs1_rdata_i,
  input  logic [XLEN-1:0]       rs2_rdata_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
  input  logic [XLEN-1:0]       wb_data_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [XLEN-1:0]       ex_pc_o,
  output logic [XLEN-1:0]       ex_rs1_data_o,
  output logic [XLEN-1:0]       ex_rs2_data_o,
  output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
  output logic                  busy_o
);

  logic [NUM_REGS-1:0] eff_pending;
  logic                hazard;
  logic                accept;
  logic                ex_valid_q;
  ex_payload_t         ex_q;
  ex_payload_t         ex_d;

  assign rs1_addr_o = id_rs1_addr_i;
  assign rs2_addr_o = id_rs2_addr_i;

  // rd check covers WAW: an older write to the same register must retire first
  assign hazard = (id_uses_rs1_i && id_rs1_addr_i != '0 && eff_pending[id_rs1_addr_i])
               || (id_uses_rs2_i && id_rs2_addr_i != '0 && eff_pending[id_rs2_addr_i])
               || (id_rd_addr_i != '0 && eff_pending[id_rd_addr_i]);

  assign id_ready_o = !flush_i && !hazard && (!ex_valid_q || ex_ready_i);
  assign accept     = id_valid_i && id_ready_o;

  operand_scoreboard u_scoreboard (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .set_vld     (accept && id_rd_addr_i != '0),
    .set_addr    (id_rd_addr_i),
    .clr_vld     (wb_valid_i),
    .clr_addr    (wb_rd_addr_i),
    .eff_pending (eff_pending),
    .busy        (busy_o)
  );

  always_comb begin
    ex_d.pc       = id_pc_i;
    ex_d.rs1_data = sel_operand(id_rs1_addr_i, wb_valid_i, wb_rd_addr_i, wb_data_i, rs1_rdata_i);
    ex_d.rs2_data = sel_operand(id_rs2_addr_i, wb_valid_i, wb_rd_addr_i, wb_data_i, rs2_rdata_i);
    ex_d.rd_addr  = id_rd_addr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (flush_i) begin
      ex_valid_q <= 1'b0;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      ex_q       <= ex_d;
    end else if (ex_ready_i) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_pc_o       = ex_q.pc;
  assign ex_rs1_data_o = ex_q.rs1_data;
  assign ex_rs2_data_o = ex_q.rs2_data;
  assign ex_rd_addr_o  = ex_q.rd_addr;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus a randomized run against an array/scoreboard model.
module tb_operand_fetch;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        id_valid_i;
  logic        id_ready_o;
  logic [31:0] id_pc_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic        id_uses_rs1_i, id_uses_rs2_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_rdata_i, rs2_rdata_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_data_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o;
  logic [4:0]  ex_rd_addr_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  operand_fetch dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_pc_i(id_pc_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .id_rd_addr_i(id_rd_addr_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_rdata_i(rs1_rdata_i), .rs2_rdata_i(rs2_rdata_i),
    .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_data_i(wb_data_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_pc_o(ex_pc_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_rd_addr_o(ex_rd_addr_o), .busy_o(busy_o)
  );

  task automatic idle();
    flush_i = 0; id_valid_i = 0; id_pc_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rd_addr_i = 0;
    id_uses_rs1_i = 0; id_uses_rs2_i = 0;
    rs1_rdata_i = 0; rs2_rdata_i = 0;
    wb_valid_i = 0; wb_rd_addr_i = 0; wb_data_i = 0;
    ex_ready_i = 1;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2);
    id_valid_i = 1; id_pc_i = pc; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rd_addr_i = rd;
    id_uses_rs1_i = 1; id_uses_rs2_i = 1; rs1_rdata_i = d1; rs2_rdata_i = d2;
  endtask

  task automatic do_flush();
    idle(); flush_i = 1; step(); flush_i = 0;
  endtask

  task automatic test_reset();
    idle(); rst_ni = 0;
    #3;
    checks++; if (ex_valid_o !== 1'b0 || busy_o !== 1'b0 || ex_pc_o !== 0 || ex_rs1_data_o !== 0 ||
                  ex_rs2_data_o !== 0 || ex_rd_addr_o !== 0) begin
      errors++; $display("FAIL reset_state: valid=%b busy=%b pc=%h rs1=%h rs2=%h rd=%0d, want all 0",
                         ex_valid_o, busy_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o);
    end
    @(negedge clk_i); rst_ni = 1; step();
    // reset mid-transfer must act without a clock edge
    issue(32'h40, 1, 2, 9, 32'h1, 32'h2); ex_ready_i = 0; step(); idle(); ex_ready_i = 0;
    checks++; if (ex_valid_o !== 1'b1) begin
      errors++; $display("FAIL reset_setup_valid: got %b want 1", ex_valid_o);
    end
    #2 rst_ni = 0; #1;
    checks++; if (ex_valid_o !== 1'b0 || busy_o !== 1'b0 || ex_pc_o !== 0) begin
      errors++; $display("FAIL reset_async: valid=%b busy=%b pc=%h want 0/0/0", ex_valid_o, busy_o, ex_pc_o);
    end
    @(negedge clk_i); rst_ni = 1; idle(); step();
  endtask

  task automatic test_issue_and_raw();
    issue(32'h100, 1, 2, 3, 32'h11, 32'h22);
    @(negedge clk_i);
    checks++; if (id_ready_o !== 1'b1 || rs1_addr_o !== 5'd1 || rs2_addr_o !== 5'd2) begin
      errors++; $display("FAIL issue_ready: ready=%b a1=%0d a2=%0d want 1/1/2", id_ready_o, rs1_addr_o, rs2_addr_o);
    end
    step(); idle();
    checks++; if (ex_valid_o !== 1 || ex_rs1_data_o !== 32'h11 || ex_rs2_data_o !== 32'h22 ||
                  ex_rd_addr_o !== 5'd3 || ex_pc_o !== 32'h100 || busy_o !== 1) begin
      errors++; $display("FAIL issue_out: v=%b d1=%h d2=%h rd=%0d pc=%h busy=%b want 1/11/22/3/100/1",
                         ex_valid_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o, ex_pc_o, busy_o);
    end
    issue(32'h104, 3, 0, 5, 32'h5, 32'h0); id_uses_rs2_i = 0;
    @(negedge clk_i);
    checks++; if (id_ready_o !== 1'b0) begin
      errors++; $display("FAIL raw_stall: ready=%b want 0", id_ready_o);
    end
    step();
    wb_valid_i = 1; wb_rd_addr_i = 3; wb_data_i = 32'hABCD;
    @(negedge clk_i);
    checks++; if (id_ready_o !== 1'b1) begin
      errors++; $display("FAIL raw_wb_ready: ready=%b want 1", id_ready_o);
    end
    step(); idle();
    checks++; if (ex_valid_o !== 1 || ex_rs1_data_o !== 32'hABCD || ex_rd_addr_o !== 5'd5) begin
      errors++; $display("FAIL raw_bypass: v=%b d1=%h rd=%0d want 1/abcd/5", ex_valid_o, ex_rs1_data_o, ex_rd_addr_o);
    end
    do_flush();
  endtask

  task automatic test_x0();
    issue(32'h200, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wb_valid_i = 1; wb_rd_addr_i = 0; wb_data_i = 32'h1234;
    step(); idle();
    checks++; if (ex_valid_o !== 1 || ex_rs1_data_o !== 0 || ex_rs2_data_o !== 0) begin
      errors++; $display("FAIL x0_operand: v=%b d1=%h d2=%h want 1/0/0", ex_valid_o, ex_rs1_data_o, ex_rs2_data_o);
    end
    checks++; if (busy_o !== 1'b0) begin
      errors++; $display("FAIL x0_pending: busy=%b want 0", busy_o);
    end
    do_flush();
  endtask

  task automatic test_backpressure();
    issue(32'h300, 1, 2, 4, 32'hA1, 32'hA2); ex_ready_i = 0;
    step();
    issue(32'h304, 5, 6, 9, 32'hB1, 32'hB2); ex_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++; if (id_ready_o !== 0 || ex_valid_o !== 1 || ex_pc_o !== 32'h300 ||
                    ex_rs1_data_o !== 32'hA1 || ex_rs2_data_o !== 32'hA2 || ex_rd_addr_o !== 5'd4) begin
        errors++; $display("FAIL backpressure_hold[%0d]: rdy=%b v=%b pc=%h d1=%h d2=%h rd=%0d want 0/1/300/a1/a2/4",
                           i, id_ready_o, ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o);
      end
      step();
    end
    // new write to r4 issued alongside the writeback that retires the old one
    issue(32'h308, 1, 2, 4, 32'hC1, 32'hC2); ex_ready_i = 1;
    wb_valid_i = 1; wb_rd_addr_i = 4; wb_data_i = 32'h44;
    @(negedge clk_i);
    checks++; if (id_ready_o !== 1'b1) begin
      errors++; $display("FAIL setwins_ready: ready=%b want 1", id_ready_o);
    end
    step(); idle();
    issue(32'h30C, 4, 0, 0, 32'h0, 32'h0); id_uses_rs2_i = 0;
    @(negedge clk_i);
    checks++; if (id_ready_o !== 1'b0 || busy_o !== 1'b1 || ex_rd_addr_o !== 5'd4) begin
      errors++; $display("FAIL setwins_pending: ready=%b busy=%b rd=%0d want 0/1/4", id_ready_o, busy_o, ex_rd_addr_o);
    end
    step();
    do_flush();
  endtask

  task automatic test_flush();
    issue(32'h400, 1, 2, 7, 32'h1, 32'h2); step();
    issue(32'h404, 1, 2, 10, 32'h3, 32'h4); ex_ready_i = 0; flush_i = 1;
    @(negedge clk_i);
    checks++; if (id_ready_o !== 1'b0) begin
      errors++; $display("FAIL flush_ready: ready=%b want 0", id_ready_o);
    end
    step(); idle();
    checks++; if (ex_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_clear: v=%b busy=%b want 0/0", ex_valid_o, busy_o);
    end
  endtask

  // Reference model: register array, set of outstanding destinations, one output slot
  logic [31:0] rf [32];
  bit          pend [32];
  bit          m_valid;
  logic [31:0] m_pc, m_op1, m_op2;
  logic [4:0]  m_rd;

  function automatic bit blocks(input logic [4:0] r);
    return r != 0 && pend[r] && !(wb_valid_i && wb_rd_addr_i == r);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    if (r == 0) return 0;
    if (wb_valid_i && wb_rd_addr_i == r) return wb_data_i;
    return rf[r];
  endfunction

  task automatic test_random();
    bit exp_rdy, exp_busy, acc;
    for (int r = 0; r < 32; r++) begin rf[r] = $urandom; pend[r] = 0; end
    m_valid = 0; m_pc = 0; m_op1 = 0; m_op2 = 0; m_rd = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      id_valid_i    = ($urandom_range(0, 3) != 0);
      id_pc_i       = $urandom;
      id_rs1_addr_i = 5'($urandom_range(0, 7));
      id_rs2_addr_i = 5'($urandom_range(0, 7));
      id_rd_addr_i  = 5'($urandom_range(0, 7));
      id_uses_rs1_i = $urandom_range(0, 1) != 0;
      id_uses_rs2_i = $urandom_range(0, 1) != 0;
      rs1_rdata_i   = rf[id_rs1_addr_i];
      rs2_rdata_i   = rf[id_rs2_addr_i];
      wb_valid_i    = ($urandom_range(0, 2) == 0);
      wb_rd_addr_i  = 5'($urandom_range(0, 7));
      wb_data_i     = $urandom;
      ex_ready_i    = ($urandom_range(0, 3) != 0);
      flush_i       = ($urandom_range(0, 39) == 0);
      @(negedge clk_i);
      exp_rdy = !flush_i && (m_valid ? ex_ready_i : 1'b1) &&
                !(id_uses_rs1_i && blocks(id_rs1_addr_i)) &&
                !(id_uses_rs2_i && blocks(id_rs2_addr_i)) && !blocks(id_rd_addr_i);
      exp_busy = 0;
      for (int r = 0; r < 32; r++) exp_busy |= pend[r];
      checks++; if (id_ready_o !== exp_rdy) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b want %b", cyc, id_ready_o, exp_rdy);
      end
      checks++; if (ex_valid_o !== m_valid || busy_o !== exp_busy) begin
        errors++; $display("FAIL rand_state[%0d]: v=%b busy=%b want %b/%b", cyc, ex_valid_o, busy_o, m_valid, exp_busy);
      end
      if (m_valid) begin
        checks++; if (ex_pc_o !== m_pc || ex_rs1_data_o !== m_op1 || ex_rs2_data_o !== m_op2 || ex_rd_addr_o !== m_rd) begin
          errors++; $display("FAIL rand_payload[%0d]: pc=%h d1=%h d2=%h rd=%0d want %h/%h/%h/%0d", cyc,
                             ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o, m_pc, m_op1, m_op2, m_rd);
        end
      end
      acc = id_valid_i && exp_rdy;
      if (flush_i) begin
        for (int r = 0; r < 32; r++) pend[r] = 0;
        m_valid = 0;
      end else begin
        if (wb_valid_i) pend[wb_rd_addr_i] = 0;
        if (acc) begin
          if (id_rd_addr_i != 0) pend[id_rd_addr_i] = 1;
          m_valid = 1; m_pc = id_pc_i; m_rd = id_rd_addr_i;
          m_op1 = operand(id_rs1_addr_i); m_op2 = operand(id_rs2_addr_i);
        end else if (ex_ready_i) begin
          m_valid = 0;
        end
      end
      if (wb_valid_i && wb_rd_addr_i != 0) rf[wb_rd_addr_i] = wb_data_i;
      step();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_issue_and_raw();
    test_x0();
    test_backpressure();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage for the in-order core: accepts one decoded instruction per cycle, drives the register file read addresses, and hands source operands to execute over a valid/ready handshake. A one-bit-per-register scoreboard tracks outstanding writes. It stalls on RAW/WAW hazards and bypasses the same-cycle writeback value, because the register file write lands only on the next clock edge. It sits between decode and execute, on the read side of the register file.

## Interface
- XLEN, 32, datapath width
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- flush_i  in  1  drop held instruction, clear scoreboard
- id_valid_i  in  1  decode has an instruction
- id_ready_o  out  1  stage accepts this cycle
- id_pc_i  in  XLEN  instruction PC
- id_rs1_addr_i, id_rs2_addr_i  in  5  source registers
- id_uses_rs1_i, id_uses_rs2_i  in  1  source actually read
- id_rd_addr_i  in  5  destination register; 0 means no write
- rs1_addr_o, rs2_addr_o  out  5  register file read addresses; combinational copies of the id_ addresses
- rs1_rdata_i, rs2_rdata_i  in  XLEN  combinational register file read data
- wb_valid_i  in  1  register file write this cycle
- wb_rd_addr_i  in  5  write address
- wb_data_i  in  XLEN  write data
- ex_valid_o  out  1  operands valid
- ex_ready_i  in  1  execute accepts
- ex_pc_o  out  XLEN  held PC
- ex_rs1_data_o, ex_rs2_data_o  out  XLEN  held operands
- ex_rd_addr_o  out  5  held destination register
- busy_o  out  1  OR of all pending bits

## Operation
- pending[31:0]: bit 0 is tied to 0.
- The effective pending vector excludes wb_rd_addr_i when wb_valid_i=1.
- hazard = (uses_rs1 & rs1≠0 & eff[rs1]) | (uses_rs2 & rs2≠0 & eff[rs2]) | (rd≠0 & eff[rd]).
- id_ready_o = !hazard & (!ex_valid_o | ex_ready_i).
- id_ready_o is combinational from ex_ready_i, wb_* and the id_* fields.
- Operand selection, per source:
  - address 0 gives 0;
  - otherwise, if wb_valid_i and wb_rd_addr_i equals the address, wb_data_i;
  - otherwise the register file data.
- Accept (id_valid_i & id_ready_o):
  - output register loads PC, operands and rd;
  - ex_valid_o is set;
  - pending[rd] is set when rd≠0.
- Execute handshake (ex_valid_o & ex_ready_i) with no accept in the same cycle: ex_valid_o is cleared.
- The output register holds steady while ex_valid_o=1 and ex_ready_i=0.
- A writeback clears pending[wb_rd_addr_i].
- Set and clear of the same bit in the same cycle: set wins.
- wb_valid_i to address 0, or to a clear bit: no effect.
- flush_i has priority over everything:
  - ex_valid_o cleared;
  - pending cleared;
  - no accept that cycle; id_ready_o is forced 0.
- The system asserts flush_i only when no writes older than the flushed instructions remain outstanding beyond the writeback port.

## Timing
- Reset (asynchronous, immediate): ex_valid_o=0, ex_pc_o/ex_rs*_data_o=0, ex_rd_addr_o=0, pending=0, busy_o=0.
- Latency: one cycle from accept to ex_valid_o.
- Throughput: one instruction per cycle when execute is ready and there is no hazard.
- A RAW-dependent instruction accepts in the same cycle its producer's wb_valid_i is seen, through the bypass. No earlier forwarding exists.
- ex_* outputs are registered; id_ready_o and rs*_addr_o are combinational.

## Structure
- core_pkg holds:
  - XLEN default;
  - REG_ADDR_W=5;
  - a packed struct for the execute payload (pc, rs1_data, rs2_data, rd_addr).
- Sub-module operand_scoreboard owns the pending vector and its rules:
  - set, clear and flush;
  - set-wins rule;
  - effective-pending output;
  - busy_o.
- The top level owns the bypass muxes, hazard logic and output register.

## Test plan
- Reset: drop rst_ni mid-transfer with ex_valid_o=1 → ex_valid_o=0 and busy_o=0 immediately, with no clock edge.
- Issue: rs1=1, rs2=2, rd=3, register file returns 0x11/0x22 → next cycle ex_valid_o=1, operands 0x11/0x22, ex_rd_addr_o=3, busy_o=1.
- RAW stall and bypass:
  - stimulus: issue rs1=3 while pending[3] → id_ready_o=0;
  - then wb_valid_i with rd=3, data 0xABCD while the register file returns stale 0x5 → id_ready_o=1 that cycle, and the captured operand is 0xABCD.
- x0: rs1=0, register file returns 0xFFFFFFFF, wb to rd=0 → operand is 0. Accept with rd=0 leaves pending unchanged.
- Backpressure and set-wins:
  - ex_ready_i=0 for 3 cycles → outputs stable, id_ready_o=0;
  - accept rd=4 in the same cycle as a wb to rd=4 → pending[4]=1 afterwards.
- Flush: flush_i with ex_valid_o=1 and pending[7]=1 → next cycle ex_valid_o=0 and busy_o=0. id_valid_i is not accepted during the flush cycle.
